// File: rtl/bnn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bnn_pkg
// Description : Shared types and helpers for the MNIST BNN datapath.
//               - Conv-engine state encoding.
//               - Popcount width function.
//               - Flat-vector index helpers for pixels, weights and outputs.
//               Layer-one, the conv/pool block and the dense stage all use
//               the same index helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Width that holds a match count of 0..9*in_ch.
  function automatic int cnt_w(input int in_ch);
    return $clog2(9 * in_ch + 1);
  endfunction

  // Bit index of channel ch of pixel (r,c) in a flat feature map.
  function automatic int pixel_idx(input int r, input int c, input int ch,
                                   input int img_dim, input int in_ch);
    return (r * img_dim + c) * in_ch + ch;
  endfunction

  // Bit index of channel ch of kernel tap (kr,kc) of filter f.
  function automatic int weight_idx(input int f, input int kr, input int kc,
                                    input int ch, input int in_ch);
    return f * 9 * in_ch + (kr * 3 + kc) * in_ch + ch;
  endfunction

  // Bit index of output (r,c) of filter f in an od x od output plane.
  function automatic int out_idx(input int f, input int r, input int c,
                                 input int od);
    return f * od * od + r * od + c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/bnn_xnor_popcount.sv
`default_nettype none
// ============================================================================
// Module      : bnn_xnor_popcount
// Description : Combinational XNOR-popcount over one 3x3 window.
// Ports       : window  - 9 neighbour pixels, IN_CH bits each.
//                         Padded neighbours must be presented as zero.
//               weights - matching 9*IN_CH weight slice of one filter.
//               count   - number of positions where window == weights.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_xnor_popcount
  import bnn_pkg::*;
#(
  parameter int IN_CH = 8,
  parameter int CNT_W = cnt_w(IN_CH)
) (
  input  logic [9*IN_CH-1:0] window,
  input  logic [9*IN_CH-1:0] weights,
  output logic [CNT_W-1:0]   count
);

  logic [9*IN_CH-1:0] match;

  assign match = ~(window ^ weights);

  always_comb begin
    count = '0;
    for (int i = 0; i < 9 * IN_CH; i++) begin
      count = count + CNT_W'(match[i]);
    end
  end

endmodule
`default_nettype wire

// File: rtl/bnn_conv_pool.sv
`default_nettype none
// ============================================================================
// Module      : bnn_conv_pool
// Description : Start/done-handshaked 3x3 binary convolution engine.
//               - Evaluates one input position per cycle.
//               - Applies an optional 2x2 max-pool.
//               - Writes results into a registered output buffer.
// Ports       : clk, rst           - clock, synchronous active-high reset.
//               start              - job request, accepted only in IDLE.
//               pool_en            - 1 = 2x2 max-pool; sampled on accept.
//               thresholds         - per-filter thresholds; sampled on accept.
//               pixels, weights    - feature map and kernels; held stable
//                                    while busy.
//               layer_out          - result buffer.
//               busy, done         - running flag, one-cycle completion pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module bnn_conv_pool
  import bnn_pkg::*;
#(
  parameter int IMG_DIM  = 14,
  parameter int IN_CH    = 8,
  parameter int NUM_FILT = 4,
  parameter int CNT_W    = cnt_w(IN_CH)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               start,
  input  logic                               pool_en,
  input  logic [NUM_FILT*CNT_W-1:0]          thresholds,
  input  logic [IMG_DIM*IMG_DIM*IN_CH-1:0]   pixels,
  input  logic [NUM_FILT*9*IN_CH-1:0]        weights,
  output logic [NUM_FILT*IMG_DIM*IMG_DIM-1:0] layer_out,
  output logic                               busy,
  output logic                               done
);

  localparam int WIN_W = 9 * IN_CH;
  localparam int OUT_W = NUM_FILT * IMG_DIM * IMG_DIM;
  localparam int FW    = (NUM_FILT > 1) ? $clog2(NUM_FILT) : 1;
  localparam int DW    = $clog2(IMG_DIM);

  state_e                    state_q, state_d;
  logic                      pool_q, pool_d;
  logic [NUM_FILT*CNT_W-1:0] thr_q, thr_d;
  logic [FW-1:0]             f_q, f_d;
  logic [DW-1:0]             r_q, r_d;
  logic [DW-1:0]             c_q, c_d;
  logic [1:0]                sub_q, sub_d;
  logic                      acc_q, acc_d;
  logic [OUT_W-1:0]          layer_out_q, layer_out_d;

  int                        pos_y, pos_x, od, wr_idx;
  logic [WIN_W-1:0]          window;
  logic [WIN_W-1:0]          w_slice;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          thr_f;
  logic                      hit;
  logic                      last_sub;

  // The input position for this cycle. In pooled mode, sub-position
  // bits {y,x} select the offset inside the 2x2 block.
  always_comb begin
    od     = pool_q ? IMG_DIM / 2 : IMG_DIM;
    pos_y  = pool_q ? 2 * int'(r_q) + int'(sub_q[1]) : int'(r_q);
    pos_x  = pool_q ? 2 * int'(c_q) + int'(sub_q[0]) : int'(c_q);
    wr_idx = out_idx(int'(f_q), int'(r_q), int'(c_q), od);
  end

  // Window mux. Taps outside the image stay zero. A zero pad therefore
  // still matches a 0 weight in the XNOR.
  always_comb begin
    int ny, nx;
    window = '0;
    for (int kr = 0; kr < 3; kr++) begin
      for (int kc = 0; kc < 3; kc++) begin
        ny = pos_y + kr - 1;
        nx = pos_x + kc - 1;
        if (ny >= 0 && ny < IMG_DIM && nx >= 0 && nx < IMG_DIM) begin
          window[(kr*3+kc)*IN_CH +: IN_CH] =
            pixels[pixel_idx(ny, nx, 0, IMG_DIM, IN_CH) +: IN_CH];
        end
      end
    end
  end

  assign w_slice = weights[weight_idx(int'(f_q), 0, 0, 0, IN_CH) +: WIN_W];
  assign thr_f   = thr_q[int'(f_q)*CNT_W +: CNT_W];

  bnn_xnor_popcount #(
    .IN_CH (IN_CH),
    .CNT_W (CNT_W)
  ) u_popcount (
    .window  (window),
    .weights (w_slice),
    .count   (count)
  );

  assign hit      = (count >= thr_f);
  assign last_sub = !pool_q || (sub_q == 2'd3);

  always_comb begin
    state_d     = state_q;
    pool_d      = pool_q;
    thr_d       = thr_q;
    f_d         = f_q;
    r_d         = r_q;
    c_d         = c_q;
    sub_d       = sub_q;
    acc_d       = acc_q;
    layer_out_d = layer_out_q;

    case (state_q)
      ST_IDLE: begin
        f_d   = '0;
        r_d   = '0;
        c_d   = '0;
        sub_d = '0;
        acc_d = 1'b0;
        if (start) begin
          pool_d      = pool_en;
          thr_d       = thresholds;
          layer_out_d = '0;
          state_d     = ST_RUN;
        end
      end

      ST_RUN: begin
        if (pool_q) begin
          // acc_q holds the OR of earlier sub-positions of this block.
          acc_d = (sub_q == 2'd0) ? hit : (acc_q | hit);
          if (sub_q == 2'd3) begin
            layer_out_d[wr_idx] = acc_q | hit;
          end
        end else begin
          layer_out_d[wr_idx] = hit;
        end

        if (!last_sub) begin
          sub_d = sub_q + 2'd1;
        end else begin
          sub_d = '0;
          if (int'(c_q) == od - 1) begin
            c_d = '0;
            if (int'(r_q) == od - 1) begin
              r_d = '0;
              if (int'(f_q) == NUM_FILT - 1) begin
                state_d = ST_DONE;
              end else begin
                f_d = f_q + 1'b1;
              end
            end else begin
              r_d = r_q + 1'b1;
            end
          end else begin
            c_d = c_q + 1'b1;
          end
        end
      end

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pool_q      <= 1'b0;
      thr_q       <= '0;
      f_q         <= '0;
      r_q         <= '0;
      c_q         <= '0;
      sub_q       <= '0;
      acc_q       <= 1'b0;
      layer_out_q <= '0;
    end else begin
      state_q     <= state_d;
      pool_q      <= pool_d;
      thr_q       <= thr_d;
      f_q         <= f_d;
      r_q         <= r_d;
      c_q         <= c_d;
      sub_q       <= sub_d;
      acc_q       <= acc_d;
      layer_out_q <= layer_out_d;
    end
  end

  assign layer_out = layer_out_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: doc/bnn_conv_pool.md
# bnn_conv_pool

Parametrised binary convolution layer for the MNIST BNN datapath. It computes a 3×3 XNOR-popcount convolution over a zero-padded `IMG_DIM`×`IMG_DIM`×`IN_CH` binary feature map for `NUM_FILT` filters. Each result is compared against a per-filter threshold supplied at run time. When pooling is enabled, 2×2 max-pooling is applied. The block sits between layer-one and the dense stage and replaces the fixed 14×14×8 / 4-filter layer with a start/done-handshaked engine that evaluates one convolution position per cycle into a registered output buffer.

## Interface
Parameters:
- `IMG_DIM`, 14: input height/width; must be even.
- `IN_CH`, 8: input channels per pixel.
- `NUM_FILT`, 4: number of filters.
- `CNT_W`, derived as `$clog2(9*IN_CH+1)` (7 at defaults): popcount/threshold width.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: single-cycle request; accepted only in IDLE.
- `pool_en` in 1: 1 = 2×2 max-pool, 0 = no pool; sampled on start accept.
- `thresholds` in NUM_FILT*CNT_W: filter f threshold at `[f*CNT_W +: CNT_W]`; sampled on start accept.
- `pixels` in IMG_DIM²·IN_CH: bit `(r*IMG_DIM+c)*IN_CH+ch`; must be stable while `busy`.
- `weights` in NUM_FILT·9·IN_CH: bit `f*9*IN_CH+(kr*3+kc)*IN_CH+ch`; must be stable while `busy`.
- `layer_out` out NUM_FILT·IMG_DIM²: registered result; bit `f*OD*OD+r*OD+c`, with OD = IMG_DIM/2 if pooled, else IMG_DIM. Bits above the used range read 0.
- `busy` out 1: high in RUN.
- `done` out 1: one-cycle pulse at completion.

## Operation
- States: IDLE, RUN, DONE (encoding in package).
- **IDLE**
  - On `start`: latch `pool_en` and `thresholds`.
  - Clear `layer_out` to 0 and zero all counters.
  - Go to RUN.
- **RUN**
  - Loop order, outer to inner: filter f (0..NUM_FILT-1), output row r (0..OD-1), output col c (0..OD-1), sub-position q.
  - q ranges 0..3 (pooled: offsets (0,0),(0,1),(1,0),(1,1) from (2r,2c)) or 0 only (unpooled: position (r,c)).
  - Each cycle evaluates one input position (y,x):
    - Match count = popcount of XNOR between the 9 neighbour pixels and filter f's 9·IN_CH weights.
    - Neighbours outside 0..IMG_DIM-1 are all-zero pixels, still XNORed against their weights, so a zero pad matches a 0 weight.
  - Hit = (count >= threshold[f]), unsigned, CNT_W bits.
  - Pooled: the OR accumulator is reset at q=0. At q=3, write `acc|hit` to `layer_out[f,r,c]`.
  - Unpooled: write `hit` every cycle.
  - After the last position of the last filter, go to DONE.
- **DONE**: assert `done` for one cycle, then go to IDLE. `layer_out` holds until the next accepted start or reset.
- **Ignored starts:** `start` in RUN or DONE is ignored and not queued.
- **Reset:**
  - State IDLE, `busy`=0, `done`=0, `layer_out`=0, counters 0.
  - Reset mid-RUN abandons the job with no done pulse.
  - Reset wins over a simultaneous `start`.

## Timing
- Start accepted at edge T; `busy` is high from T+1.
- RUN lasts N = NUM_FILT·IMG_DIM² cycles in either mode (784 at defaults).
- `done` is high for the single cycle after RUN completes (T+N+1). `busy` is low in that cycle.
- Final `layer_out` is valid when `done` rises.
- Earliest next start acceptance is the cycle after `done`.
- Popcount and compare are combinational within a cycle; no pipelining at defaults.

## Structure
- Package `bnn_pkg`:
  - state typedef/localparams (IDLE/RUN/DONE);
  - `CNT_W` computation function;
  - pixel/weight/output index functions shared with layer-one and the dense stage.
- Sub-module `bnn_xnor_popcount`:
  - combinational; ports IN_CH/padding-aware 9-pixel window, weight slice, CNT_W count;
  - reusable by later conv layers.
- Top holds the FSM, counters, window extraction mux and output register.

## Test plan
- **All-match, no pool:** pixels=0, weights=0, thresh=72 for all filters, `pool_en`=0 → all 784 `layer_out` bits are 1; `done` occurs exactly 785 cycles after start.
- **Impossible threshold:** thresh=73, any data → `layer_out`=0; `done` still pulses once.
- **Boundary padding:** pixels all 1, weights all 1, thresh=49, `pool_en`=0 → the 4 corners per filter are 0 (count 32), edge non-corners are 0 (count 48), interior is 1 (count 72). With `pool_en`=1 at the same thresh → all 49 bits per filter are 1, and bits ≥196 are 0.
- **Per-filter thresholds:** thresh = {72, 73, 72, 73} for filters 0..3, zero data, `pool_en`=1 → filters 0 and 2 are all 1, filters 1 and 3 are all 0.
- **Handshake:**
  - `start` re-asserted at cycle 100 of RUN → no effect on timing or result.
  - `start` held high through DONE → the next job is accepted only in IDLE.
  - Thresholds changed mid-run → no effect on the result.
- **Reset mid-op:** `rst` at cycle 300 → next cycle `busy`=0, `layer_out`=0, no `done`. A following start completes normally.
